// File: rtl/stream_pkg.sv
// stream_pkg: shared constants and helpers for stream blocks
package stream_pkg;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (c == DROP_CNT_MAX) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: one-entry output register with load, drain and valid flag
module stream_demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    valid_d = load_i ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
    data_d  = load_i ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready demux with out-of-range drop counting
module stream_demux
  import stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W-1:0]          s_data,
  input  logic [SEL_W-1:0]      s_sel,
  output logic [N-1:0]          m_valid,
  input  logic [N-1:0]          m_ready,
  output logic [N*W-1:0]        m_data,
  output logic                  err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam logic [SEL_W:0] NL = N[SEL_W:0];
  logic                  in_range, acc, drop, err_q, err_d;
  logic [DROP_CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    in_range = {1'b0, s_sel} < NL;
    s_ready  = in_range ? (!m_valid[s_sel] || m_ready[s_sel]) : 1'b1;
    acc      = s_valid && s_ready;
    drop     = acc && !in_range;
    err_d    = drop;
    cnt_d    = drop ? sat_inc(cnt_q) : cnt_q;
  end
  for (genvar i = 0; i < N; i++) begin : g_slot
    stream_demux_slot #(.W(W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load_i (acc && in_range && s_sel == SEL_W'(i)),
      .data_i (s_data),
      .ready_i(m_ready[i]),
      .valid_o(m_valid[i]),
      .data_o (m_data[i*W +: W])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign err      = err_q;
  assign drop_cnt = cnt_q;
endmodule
